hashcam_keyhash: RTL and testbench
==================================

// Module: hashcam_keyhash
// PURPOSE
//  Octet-serial CRC-8 key hasher sitting directly upstream of HashCAM: turns a
//  KEY_WIDTH_IN_OCTETS-octet key into the 8-bit bucket index HashCAM uses.
//  Drives the blockhash_enable/blockhash_ready/key_hash handshake on HashCAM's
//  hash port; also returns the captured key aligned with the hash.
// PARAMETERS
//  KEY_WIDTH_IN_OCTETS  2  key width in octets (>=1); must match HashCAM.
// PORTS
//  clk               in   1        single clock; all state on posedge
//  reset             in   1        synchronous, active-high
//  blockhash_enable  in   1        request: sample key_to_hash this cycle
//  key_to_hash       in   8*KWO    key, octet [8*KWO-1 -: 8] hashed first
//  blockhash_ready   out  1        1-cycle pulse: key_hash/key_out valid
//  key_hash          out  8        CRC-8 of key; held until next result
//  key_out           out  8*KWO    key that produced key_hash; held likewise
//  busy              out  1        1 while a hash is in progress
//  dropped           out  1        1-cycle pulse: enable arrived while busy
//  (KWO = KEY_WIDTH_IN_OCTETS)
// BEHAVIOUR
//  - Reset (sync, high): state IDLE; blockhash_ready, key_hash, key_out, busy,
//    dropped all 0; CRC accumulator 0, octet counter 0. Reset wins over every
//    other event, including mid-hash: the in-flight hash is abandoned and no
//    ready pulse is produced for it.
//  - CRC: poly 0x07, init 0x00, no reflection, no final XOR (CRC-8/SMBUS).
//    Per octet: crc = step(crc ^ octet), 8 shift/XOR iterations, combinational
//    within one cycle. All arithmetic 8-bit, MSB-first.
//  - FSM IDLE -> HASH -> DONE -> IDLE:
//    IDLE: busy=0. enable=1 at edge E: capture key into shift reg + key_out
//      staging reg, crc<=0, cnt<=KWO, go HASH.
//    HASH: busy=1. Each edge consumes top octet, shifts reg left 8, cnt-1;
//      on the edge consuming the last octet (cnt==1) write key_hash and
//      key_out, go DONE. Edges E+1..E+KWO.
//    DONE: blockhash_ready=1 for exactly this cycle, busy=0. If enable=1 here
//      it is accepted exactly as in IDLE (-> HASH); else -> IDLE.
//  - Latency: enable sampled at edge E -> blockhash_ready high in cycle after
//    edge E+KWO. Max throughput one key per KWO+1 cycles.
//  - enable=1 while busy=1: ignored, in-flight hash unaffected, dropped=1 the
//    following cycle. key_to_hash only sampled at acceptance edge.
//  - key_hash/key_out change only at the completion edge; stable otherwise.
//  - KWO=1: HASH lasts one cycle; counter width $clog2(KWO+1), no wrap.
// STRUCTURE
//  - hashcam_pkg: CRC8_POLY=8'h07, CRC8_INIT=8'h00, HASH_WIDTH=8, FSM state
//    enum {IDLE,HASH,DONE}, function crc8_octet(crc,octet) -> next crc.
//  - One sub-module natural: none required; crc8_octet kept as package
//    function so HashCAM-side checkers and the bench reuse the same model.
//  - Top: FSM, octet counter, key shift register, output registers.
// TESTING
//  1. Reset: hold reset 2 cycles -> all outputs 0; enable during reset ignored.
//  2. KWO=2, key 16'h000A at edge E -> ready pulse after edge E+2,
//     key_hash=8'h36, key_out=16'h000A; 16'h0001 -> 8'h07; 16'h0100 -> 8'h15;
//     16'h0000 -> 8'h00.
//  3. KWO=9, key ASCII "123456789" -> key_hash=8'hF4 after 9 HASH cycles.
//  4. Back-to-back: enable held high, keys 16'h000A then 16'h0001 -> second
//     accepted in DONE, ready pulses 3 cycles apart, hashes 8'h36, 8'h07.
//  5. Enable at E+1 while busy with 16'h000A -> dropped pulse once, result
//     still 8'h36, no extra ready pulse.
//  6. Reset asserted at E+1 mid-hash -> no ready pulse, outputs 0; next key
//     16'h0100 hashes cleanly to 8'h15.

Source files
------------

// File: rtl/hashcam_pkg.sv
// Shared CRC-8/SMBUS constants, FSM state type and the per-octet CRC step
// used by the key hasher and by anything that needs to predict HashCAM bucket indices.
package hashcam_pkg;

  localparam int         HASH_WIDTH = 8;
  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam logic [7:0] CRC8_INIT  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } state_t;

  // MSB-first, unreflected CRC-8 over one octet.
  function automatic logic [7:0] crc8_octet(input logic [7:0] crc, input logic [7:0] octet);
    logic [7:0] c;
    c = crc ^ octet;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/hashcam_keyhash.sv
// Octet-serial CRC-8 key hasher feeding HashCAM's hash port: one octet per cycle,
// result and originating key presented with a one-cycle blockhash_ready pulse.
module hashcam_keyhash
  import hashcam_pkg::*;
#(
  parameter int KEY_WIDTH_IN_OCTETS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             blockhash_enable,
  input  logic [8*KEY_WIDTH_IN_OCTETS-1:0] key_to_hash,
  output logic                             blockhash_ready,
  output logic [HASH_WIDTH-1:0]            key_hash,
  output logic [8*KEY_WIDTH_IN_OCTETS-1:0] key_out,
  output logic                             busy,
  output logic                             dropped
);

  localparam int KW = 8 * KEY_WIDTH_IN_OCTETS;
  localparam int CW = $clog2(KEY_WIDTH_IN_OCTETS + 1);

  state_t          state;
  state_t          state_next;
  logic [KW-1:0]   shreg;
  logic [KW-1:0]   stage;
  logic [7:0]      crc;
  logic [7:0]      crc_next;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (blockhash_enable) begin
          accept     = 1'b1;
          state_next = HASH;
        end
      end
      HASH: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        // A new key can be accepted in the same cycle the previous result is presented.
        if (blockhash_enable) begin
          accept     = 1'b1;
          state_next = HASH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last            = (state == HASH) && (cnt == CW'(1));
  assign crc_next        = crc8_octet(crc, shreg[KW-1 -: 8]);
  assign blockhash_ready = (state == DONE);
  assign busy            = (state == HASH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      stage    <= '0;
      crc      <= CRC8_INIT;
      cnt      <= '0;
      key_hash <= '0;
      key_out  <= '0;
      dropped  <= 1'b0;
    end else begin
      state   <= state_next;
      dropped <= blockhash_enable && (state == HASH);
      if (accept) begin
        shreg <= key_to_hash;
        stage <= key_to_hash;
        crc   <= CRC8_INIT;
        cnt   <= CW'(KEY_WIDTH_IN_OCTETS);
      end else if (state == HASH) begin
        shreg <= shreg << 8;
        crc   <= crc_next;
        cnt   <= cnt - CW'(1);
        if (last) begin
          key_hash <= crc_next;
          key_out  <= stage;
        end
      end
    end
  end

endmodule

// File: tb/tb_hashcam_keyhash.sv
// Directed-vector bench with a queue scoreboard for a 2-octet and a 9-octet hasher.
module tb_hashcam_keyhash;

  logic        clk = 1'b0;
  logic        reset;
  logic        en2, en9;
  logic [15:0] key2;
  logic [71:0] key9;
  logic        rdy2, rdy9, busy2, busy9, drop2, drop9;
  logic [7:0]  hash2, hash9;
  logic [15:0] kout2;
  logic [71:0] kout9;

  always #5 clk = ~clk;

  hashcam_keyhash #(.KEY_WIDTH_IN_OCTETS(2)) dut2 (
    .clk(clk), .reset(reset), .blockhash_enable(en2), .key_to_hash(key2),
    .blockhash_ready(rdy2), .key_hash(hash2), .key_out(kout2), .busy(busy2), .dropped(drop2)
  );

  hashcam_keyhash #(.KEY_WIDTH_IN_OCTETS(9)) dut9 (
    .clk(clk), .reset(reset), .blockhash_enable(en9), .key_to_hash(key9),
    .blockhash_ready(rdy9), .key_hash(hash9), .key_out(kout9), .busy(busy9), .dropped(drop9)
  );

  typedef struct {
    logic [7:0]  h;
    logic [71:0] k;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q9[$];
  int   total = 0;
  int   bad   = 0;
  int   ncnt  = 0;
  int   ndrop2 = 0;
  int   ndrop9 = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: cycle index advances first so drivers see the current cycle number.
  always @(negedge clk) begin
    exp_t e;
    ncnt++;
    if (drop2 === 1'b1) ndrop2++;
    if (drop9 === 1'b1) ndrop9++;
    if (rdy2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_ready2", 72'(rdy2), 72'd0);
      end else begin
        e = q2.pop_front();
        chk("hash2", 72'(hash2), 72'(e.h));
        chk("key_out2", 72'(kout2), e.k);
        chk("ready2_cycle", 72'(ncnt), 72'(e.cyc));
      end
    end
    if (rdy9 === 1'b1) begin
      if (q9.size() == 0) begin
        chk("unexpected_ready9", 72'(rdy9), 72'd0);
      end else begin
        e = q9.pop_front();
        chk("hash9", 72'(hash9), 72'(e.h));
        chk("key_out9", kout9, e.k);
        chk("ready9_cycle", 72'(ncnt), 72'(e.cyc));
      end
    end
  end

  task automatic send2(input logic [15:0] k, input logic [7:0] h);
    @(negedge clk); #1;
    en2  = 1'b1;
    key2 = k;
    q2.push_back('{h: h, k: 72'(k), cyc: ncnt + 3});
    @(negedge clk); #1;
    en2 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q2.size() != 0 || q9.size() != 0); i++) @(negedge clk);
    if (q2.size() != 0 || q9.size() != 0) begin
      chk("drain_timeout", 72'(q2.size() + q9.size()), 72'd0);
      q2.delete();
      q9.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle2(input string name);
    chk({name, "_ready"}, 72'(rdy2), 72'd0);
    chk({name, "_hash"},  72'(hash2), 72'd0);
    chk({name, "_key"},   72'(kout2), 72'd0);
    chk({name, "_busy"},  72'(busy2), 72'd0);
    chk({name, "_drop"},  72'(drop2), 72'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    en2 = 1'b1; key2 = 16'h1234;
    en9 = 1'b1; key9 = 72'h1;
    repeat (2) @(negedge clk);
    #1;
    chk_idle2("reset");
    chk("reset_hash9", 72'(hash9), 72'd0);
    chk("reset_busy9", 72'(busy9), 72'd0);
    @(negedge clk); #1;
    reset = 1'b0; en2 = 1'b0; en9 = 1'b0;
    repeat (2) @(negedge clk);

    // Single keys on the 2-octet hasher.
    send2(16'h000A, 8'h36); drain();
    send2(16'h0001, 8'h07); drain();
    send2(16'h0100, 8'h15); drain();
    send2(16'h0000, 8'h00); drain();

    // 9-octet check string.
    @(negedge clk); #1;
    en9  = 1'b1;
    key9 = 72'h313233343536373839;
    q9.push_back('{h: 8'hF4, k: 72'h313233343536373839, cyc: ncnt + 10});
    @(negedge clk); #1;
    en9 = 1'b0;
    #1 chk("busy9_mid", 72'(busy9), 72'd1);
    drain();

    // Back-to-back with enable held: second key accepted in DONE, two drops meanwhile.
    d0 = ndrop2;
    @(negedge clk); #1;
    en2 = 1'b1; key2 = 16'h000A;
    q2.push_back('{h: 8'h36, k: 72'h000A, cyc: ncnt + 3});
    @(negedge clk); #1;
    @(negedge clk); #1;
    key2 = 16'h0001;
    @(negedge clk); #1;
    q2.push_back('{h: 8'h07, k: 72'h0001, cyc: ncnt + 3});
    @(negedge clk); #1;
    en2 = 1'b0;
    drain();
    chk("b2b_drops", 72'(ndrop2 - d0), 72'd2);

    // Enable while busy: one drop, result unaffected.
    d0 = ndrop2;
    @(negedge clk); #1;
    en2 = 1'b1; key2 = 16'h000A;
    q2.push_back('{h: 8'h36, k: 72'h000A, cyc: ncnt + 3});
    @(negedge clk); #1;
    key2 = 16'hFFFF;
    @(negedge clk); #1;
    en2 = 1'b0;
    drain();
    chk("busy_drops", 72'(ndrop2 - d0), 72'd1);
    chk("busy_hold_hash", 72'(hash2), 72'h36);

    // Reset mid-hash: no ready pulse (monitor flags any), outputs cleared.
    @(negedge clk); #1;
    en2 = 1'b1; key2 = 16'h000A;
    @(negedge clk); #1;
    en2 = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk_idle2("midreset");
    repeat (5) @(negedge clk);
    send2(16'h0100, 8'h15); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
